// File: rtl/fifo_write_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the round-robin FIFO write arbiter.
// The arbiter connects through the slave modport; requesters and the FIFO model use master.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full;
    logic                     fifo_in_ready;
    logic [WIDTH-1:0]         fifo_data_in;
    logic [GW-1:0]            grant_id;
    logic                     busy;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_in_ready, fifo_data_in, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_in_ready, fifo_data_in, grant_id, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_ARB_STALL_RELEASE_EN to release a grant after STALL_LIMIT consecutive full stalls.
module fifo_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int MAX_BURST   = 4,
    parameter int STALL_LIMIT = 16
) (
    input logic               clk,
    input logic               reset_n,
    fifo_write_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_reg;
    logic [GW-1:0]   grant_id_reg;
    logic [GW-1:0]   last_grant_reg;
    logic [BW-1:0]   beat_cnt_reg;

    logic [GW-1:0]   next_grant;
    logic [GW-1:0]   cand;
    logic            any_req;
    logic            in_burst;
    logic            beat;
    logic            stalled;
    logic            stall_release;
    logic            burst_done;
    logic [WIDTH-1:0] slot [NUM_REQ];

    // Scan last_grant+1 .. last_grant+NUM_REQ with an explicit wrap so that
    // non-power-of-two NUM_REQ never produces an out-of-range grant.
    always_comb begin
        next_grant = last_grant_reg;
        any_req    = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant_reg) + k) % NUM_REQ);
            if (!any_req && bus.req_valid[cand]) begin
                any_req    = 1'b1;
                next_grant = cand;
            end
        end
    end

    assign in_burst = (state_reg == BURST);
    assign beat     = in_burst && bus.req_valid[grant_id_reg] && !bus.fifo_full;
    assign stalled  = in_burst && bus.req_valid[grant_id_reg] && bus.fifo_full;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign slot[gi]          = bus.req_data[gi*WIDTH +: WIDTH];
            assign bus.req_ready[gi] = beat && (grant_id_reg == GW'(gi));
        end
    endgenerate

    assign bus.fifo_in_ready = beat;
    assign bus.fifo_data_in  = slot[grant_id_reg];
    assign bus.grant_id      = grant_id_reg;
    assign bus.busy          = in_burst;

`ifdef FIFO_ARB_STALL_RELEASE_EN
    localparam int SW = $clog2(STALL_LIMIT) + 1;
    logic [SW-1:0] stall_cnt_reg;
    assign stall_release = stalled && (stall_cnt_reg == SW'(STALL_LIMIT - 1));
`else
    assign stall_release = 1'b0;
`endif

    // A withdrawn request ends the burst without a beat.
    assign burst_done = (beat && (bus.req_last[grant_id_reg] ||
                                  beat_cnt_reg == BW'(MAX_BURST - 1)))
                     || (in_burst && !bus.req_valid[grant_id_reg])
                     || stall_release;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            grant_id_reg   <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
            beat_cnt_reg   <= '0;
`ifdef FIFO_ARB_STALL_RELEASE_EN
            stall_cnt_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_id_reg <= next_grant;
                        beat_cnt_reg <= '0;
                        state_reg    <= BURST;
                    end
                end
                BURST: begin
                    if (beat)
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    if (burst_done) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= grant_id_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
`ifdef FIFO_ARB_STALL_RELEASE_EN
            if (stalled && !burst_done)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            else
                stall_cnt_reg <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: a transaction-level model predicts each write,
// a negedge monitor compares the DUT's FIFO-side outputs against the predictions.
module tb_fifo_write_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int WIDTH       = 8;
    localparam int MAX_BURST   = 4;
    localparam int STALL_LIMIT = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t              exp_q[$];
    logic [WIDTH:0]   strm [NUM_REQ][$];   // {last, data} per requester
    bit               en [NUM_REQ];
    int               obs_grants[$];
    int               n_tests = 0;
    int               n_fail  = 0;

    // expectations for the current cycle, written by the driver, read by the monitor
    bit exp_busy;
    int exp_gid;
    bit exp_wr;

    // reference arbiter state
    bit m_busy;
    int m_g, m_last, m_beats, m_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0; m_g = 0; m_last = NUM_REQ - 1; m_beats = 0; m_stalls = 0;
        exp_busy = 0; exp_gid = 0; exp_wr = 0;
        exp_q.delete();
    endfunction

    // One cycle of the arbitration rules, given this cycle's requests and full flag.
    function automatic void model_step(input logic [NUM_REQ-1:0] v, input logic full_in);
        wr_t w;
        bit  found;
        exp_busy = m_busy;
        exp_gid  = m_g;
        exp_wr   = 0;
        if (!m_busy) begin
            found = 0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (m_last + k) % NUM_REQ;
                if (!found && v[c]) begin
                    found = 1; m_g = c; m_busy = 1; m_beats = 0; m_stalls = 0;
                end
            end
        end else if (v[m_g] && !full_in) begin
            exp_wr = 1;
            w.id   = m_g;
            w.data = strm[m_g][0][WIDTH-1:0];
            exp_q.push_back(w);
            m_beats++;
            m_stalls = 0;
            if (strm[m_g][0][WIDTH] || m_beats == MAX_BURST) begin
                m_busy = 0; m_last = m_g;
            end
            void'(strm[m_g].pop_front());
        end else if (!v[m_g]) begin
            m_busy = 0; m_last = m_g;
        end else begin
            m_stalls++;
`ifdef FIFO_ARB_STALL_RELEASE_EN
            if (m_stalls == STALL_LIMIT) begin
                m_busy = 0; m_last = m_g; m_stalls = 0;
            end
`endif
        end
    endfunction

    task automatic step(input logic full_in);
        logic [NUM_REQ-1:0]       v, l;
        logic [NUM_REQ*WIDTH-1:0] d;
        @(posedge clk); #1;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (strm[i].size() > 0) begin
                v[i]                = en[i];
                l[i]                = strm[i][0][WIDTH];
                d[i*WIDTH +: WIDTH] = strm[i][0][WIDTH-1:0];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.fifo_full = full_in;
        model_step(v, full_in);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_in_ready", 32'(bus.fifo_in_ready), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic load(input int id, input int n, input int base, input bit last_at_end);
        for (int k = 0; k < n; k++)
            strm[id].push_back({(last_at_end && k == n - 1), 8'(base + k)});
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_REQ; i++) begin
            strm[i].delete();
            en[i] = 1;
        end
    endtask

    task automatic chk_grants(input string name, input int exp_list[$]);
        @(negedge clk); #1;
        chk({name, "_count"}, 32'(obs_grants.size()), 32'(exp_list.size()));
        for (int k = 0; k < exp_list.size(); k++)
            chk(name, (obs_grants.size() > k) ? 32'(obs_grants[k]) : 32'hffff_ffff, 32'(exp_list[k]));
        obs_grants.delete();
    endtask

    // Monitor: compares the DUT's outputs with the predicted write each cycle.
    initial begin
        bit  prev_busy;
        wr_t w;
        prev_busy = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("busy", 32'(bus.busy), 32'(exp_busy));
                chk("grant_id", 32'(bus.grant_id), 32'(exp_gid));
                chk("write_strobe", 32'(bus.fifo_in_ready), 32'(exp_wr));
                chk("req_ready", 32'(bus.req_ready), exp_wr ? (32'd1 << exp_gid) : 32'd0);
                if (bus.fifo_full && bus.fifo_in_ready)
                    chk("write_while_full", 32'(bus.fifo_in_ready), 0);
                if (bus.busy && !prev_busy)
                    obs_grants.push_back(int'(bus.grant_id));
                prev_busy = bus.busy;
                if (bus.fifo_in_ready && exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    chk("write_id", 32'(bus.grant_id), 32'(w.id));
                    chk("write_data", 32'(bus.fifo_data_in), 32'(w.data));
                    $display("[TB] write req=%0d data=0x%02h", bus.grant_id, bus.fifo_data_in);
                end
            end else begin
                prev_busy = 0;
            end
        end
    end

    initial begin
        int fullpat[$];
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        model_reset();
        clear_all();
        do_reset();

        // single requester, 6-beat stream split by MAX_BURST
        load(0, 6, 8'h10, 1);
        repeat (12) step(0);
        chk_grants("t1_grants", '{0, 0});

        // all requesters continuously valid: strict rotation
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) load(i, 8, 8'h20 + 16 * i, 1);
        repeat (42) step(0);
        chk_grants("t2_grants", '{0, 1, 2, 3, 0, 1, 2, 3});

        // full stall in the middle of requester 2's burst
        clear_all();
        load(2, 4, 8'h80, 1);
        fullpat = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
        foreach (fullpat[k]) step(fullpat[k][0]);
        chk_grants("t3_grants", '{2});

        // requester 1 withdraws after two beats; requester 2 wins next
        clear_all();
        load(1, 6, 8'h90, 0);
        repeat (3) step(0);
        en[1] = 0;
        step(0);
        load(0, 2, 8'ha0, 1);
        load(2, 2, 8'hb0, 1);
        repeat (8) step(0);
        chk_grants("t4_grants", '{1, 2, 0});

        // reset during requester 1's burst; requester 0 has priority afterwards
        clear_all();
        load(1, 4, 8'hc0, 1);
        repeat (2) step(0);
        do_reset();
        load(0, 2, 8'hd0, 1);
        repeat (10) step(0);
        obs_grants.delete();

        // stuck-full FIFO with requesters 0 and 1 waiting
        do_reset();
        clear_all();
        load(0, 4, 8'he0, 1);
        load(1, 4, 8'hf0, 1);
        repeat (24) step(1);
`ifdef FIFO_ARB_STALL_RELEASE_EN
        chk_grants("t6_grants", '{0, 1});
`else
        chk_grants("t6_grants", '{0});
`endif
        repeat (16) step(0);
        obs_grants.delete();

        // randomized traffic, withdrawals and back-pressure
        clear_all();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (strm[i].size() == 0 && $urandom_range(0, 3) == 0)
                    load(i, $urandom_range(1, 7), $urandom_range(0, 255), 1);
                if ($urandom_range(0, 15) == 0) en[i] = !en[i];
            end
            step($urandom_range(0, 3) == 0);
        end
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
